hssl_lpbk_tester: RTL and testbench

Parametrised multi-channel traffic generator and checker for High-Speed Serial Link (HSSL) loopback testing, both in simulation and on hardware. Each channel sends framed pseudo-random words into the HSSL transmit stream. It checks the looped-back receive stream, tracks frame lock, and keeps error and good-frame counters. It sits between the HSSL interface and the transceiver block and replaces ad-hoc loopback benches with a reusable, self-checking block.

---
 rtl/hssl_lpbk_pkg.sv | 30 +++
 rtl/hssl_lpbk_chan.sv | 221 ++++++++++++++++++++++
 rtl/hssl_lpbk_tester.sv | 49 ++++
 tb/tb_hssl_lpbk_tester.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssl_lpbk_pkg.sv
// Shared constants, state encodings and the PRBS step function for the
// HSSL loopback traffic generator/checker.
package hssl_lpbk_pkg;

    localparam logic [31:0] SYNC_WORD_DEF = 32'h5A5A_C3C3;
    localparam logic [31:0] SEED_BASE     = 32'hACE1_0000;
    // x^32 + x^22 + x^2 + x + 1 mapped onto state bits 31, 21, 1 and 0
    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam int unsigned LFSR_TAP_A    = 31;
    localparam int unsigned LFSR_TAP_B    = 21;
    localparam int unsigned LFSR_TAP_C    = 1;
    localparam int unsigned LFSR_TAP_D    = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    typedef enum logic {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } rx_state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        logic fb;
        fb = state[LFSR_TAP_A] ^ state[LFSR_TAP_B] ^ state[LFSR_TAP_C] ^ state[LFSR_TAP_D];
        return {state[30:0], fb};
    endfunction

endpackage

// File: rtl/hssl_lpbk_chan.sv
// One loopback channel: framed PRBS transmitter, frame-locking receive
// checker and saturating error / good-frame counters.
module hssl_lpbk_chan
    import hssl_lpbk_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 16,
    parameter int unsigned MISS_LIMIT  = 4,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter logic [31:0] SEED        = SEED_BASE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_in,
    input  logic                 clear_in,
    output logic [31:0]          tx_data_out,
    output logic                 tx_vld_out,
    input  logic                 tx_rdy_in,
    input  logic [31:0]          rx_data_in,
    input  logic                 rx_vld_in,
    output logic                 locked_out,
    output logic [CNT_WIDTH-1:0] err_cnt_out,
    output logic [CNT_WIDTH-1:0] frm_cnt_out
);

    localparam int unsigned    IDX_W    = $clog2(FRAME_WORDS);
    localparam int unsigned    MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

    tx_state_e          tx_state_r, tx_state_s;
    logic [IDX_W-1:0]   tx_idx_r, tx_idx_s;
    logic [31:0]        tx_lfsr_r, tx_lfsr_s;
    logic [31:0]        tx_data_r, tx_data_s;
    logic               tx_vld_r, tx_vld_s;
    logic               tx_xfer_s;

    rx_state_e          rx_state_r, rx_state_s;
    logic [IDX_W-1:0]   rx_idx_r, rx_idx_s;
    logic [31:0]        rx_exp_r, rx_exp_s;
    logic [MISS_W-1:0]  miss_r, miss_s, miss_inc_s;
    logic               frm_bad_r, frm_bad_s;
    logic               locked_r, locked_s;
    logic               rx_sync_s, rx_match_s;
    logic               err_inc_s, frm_inc_s;
    logic [CNT_WIDTH-1:0] err_cnt_r, frm_cnt_r;

    // TX next-state: a word leaves only on vld&rdy, frames always run to completion
    always_comb begin
        tx_state_s = tx_state_r;
        tx_idx_s   = tx_idx_r;
        tx_lfsr_s  = tx_lfsr_r;
        tx_data_s  = tx_data_r;
        tx_vld_s   = tx_vld_r;
        tx_xfer_s  = tx_vld_r & tx_rdy_in;
        case (tx_state_r)
            IDLE: begin
                if (enable_in) begin
                    tx_state_s = SEND;
                    tx_vld_s   = 1'b1;
                    tx_data_s  = SYNC_WORD;
                    tx_idx_s   = {IDX_W{1'b0}};
                    tx_lfsr_s  = SEED;
                end else begin
                    tx_vld_s   = 1'b0;
                end
            end
            SEND: begin
                if (!tx_xfer_s) begin
                    tx_vld_s = 1'b1;
                end else if (tx_idx_r == LAST_IDX) begin
                    if (enable_in) begin
                        tx_data_s = SYNC_WORD;
                        tx_idx_s  = {IDX_W{1'b0}};
                        tx_lfsr_s = SEED;
                    end else begin
                        tx_state_s = IDLE;
                        tx_vld_s   = 1'b0;
                    end
                end else begin
                    tx_idx_s  = tx_idx_r + IDX_W'(1);
                    tx_data_s = tx_lfsr_r;
                    tx_lfsr_s = lfsr_next(tx_lfsr_r);
                end
            end
            default: begin
                tx_state_s = IDLE;
                tx_vld_s   = 1'b0;
            end
        endcase
    end

    // TX state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_r <= IDLE;
            tx_idx_r   <= {IDX_W{1'b0}};
            tx_lfsr_r  <= SEED;
            tx_data_r  <= 32'h0000_0000;
            tx_vld_r   <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_idx_r   <= tx_idx_s;
            tx_lfsr_r  <= tx_lfsr_s;
            tx_data_r  <= tx_data_s;
            tx_vld_r   <= tx_vld_s;
        end
    end

    // RX next-state: rx_exp_r always holds the payload word expected at rx_idx_r
    always_comb begin
        rx_state_s = rx_state_r;
        rx_idx_s   = rx_idx_r;
        rx_exp_s   = rx_exp_r;
        miss_s     = miss_r;
        frm_bad_s  = frm_bad_r;
        locked_s   = locked_r;
        err_inc_s  = 1'b0;
        frm_inc_s  = 1'b0;
        rx_sync_s  = (rx_data_in == SYNC_WORD);
        rx_match_s = (rx_data_in == rx_exp_r);
        miss_inc_s = miss_r + MISS_W'(1);
        if (rx_vld_in) begin
            case (rx_state_r)
                HUNT: begin
                    if (rx_sync_s) begin
                        rx_state_s = CHECK;
                        rx_idx_s   = IDX_W'(1);
                        rx_exp_s   = SEED;
                        miss_s     = {MISS_W{1'b0}};
                        frm_bad_s  = 1'b0;
                        locked_s   = 1'b1;
                    end else begin
                        locked_s   = 1'b0;
                    end
                end
                CHECK: begin
                    if (rx_idx_r == {IDX_W{1'b0}}) begin
                        if (rx_sync_s) begin
                            rx_idx_s  = IDX_W'(1);
                            rx_exp_s  = SEED;
                            frm_bad_s = 1'b0;
                        end else begin
                            err_inc_s  = 1'b1;
                            rx_state_s = HUNT;
                            locked_s   = 1'b0;
                        end
                    end else begin
                        rx_exp_s = lfsr_next(rx_exp_r);
                        if (rx_match_s) begin
                            miss_s = {MISS_W{1'b0}};
                        end else begin
                            err_inc_s = 1'b1;
                            miss_s    = miss_inc_s;
                            frm_bad_s = 1'b1;
                        end
                        if (!rx_match_s && (miss_inc_s == MISS_MAX)) begin
                            rx_state_s = HUNT;
                            locked_s   = 1'b0;
                        end else if (rx_idx_r == LAST_IDX) begin
                            rx_idx_s  = {IDX_W{1'b0}};
                            frm_inc_s = rx_match_s & ~frm_bad_r;
                        end else begin
                            rx_idx_s  = rx_idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    rx_state_s = HUNT;
                    locked_s   = 1'b0;
                end
            endcase
        end else begin
            rx_state_s = rx_state_r;
        end
    end

    // RX state and lock registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= HUNT;
            rx_idx_r   <= {IDX_W{1'b0}};
            rx_exp_r   <= SEED;
            miss_r     <= {MISS_W{1'b0}};
            frm_bad_r  <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_idx_r   <= rx_idx_s;
            rx_exp_r   <= rx_exp_s;
            miss_r     <= miss_s;
            frm_bad_r  <= frm_bad_s;
            locked_r   <= locked_s;
        end
    end

    // Saturating counters; a clear overrides a coincident increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_r <= {CNT_WIDTH{1'b0}};
            frm_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (clear_in) begin
            err_cnt_r <= {CNT_WIDTH{1'b0}};
            frm_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (err_inc_s && (err_cnt_r != {CNT_WIDTH{1'b1}})) begin
                err_cnt_r <= err_cnt_r + CNT_WIDTH'(1);
            end
            if (frm_inc_s && (frm_cnt_r != {CNT_WIDTH{1'b1}})) begin
                frm_cnt_r <= frm_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    assign tx_data_out = tx_data_r;
    assign tx_vld_out  = tx_vld_r;
    assign locked_out  = locked_r;
    assign err_cnt_out = err_cnt_r;
    assign frm_cnt_out = frm_cnt_r;

endmodule

// File: rtl/hssl_lpbk_tester.sv
// Multi-channel HSSL loopback tester: one independent generator/checker
// per channel, buses packed 32 bits (or CNT_WIDTH bits) per channel.
module hssl_lpbk_tester
    import hssl_lpbk_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 1,
    parameter int unsigned FRAME_WORDS  = 16,
    parameter int unsigned MISS_LIMIT   = 4,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter logic [31:0] SYNC_WORD    = SYNC_WORD_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable_in,
    input  logic                              clear_in,
    output logic [32*NUM_CHANNELS-1:0]        tx_data_out,
    output logic [NUM_CHANNELS-1:0]           tx_vld_out,
    input  logic [NUM_CHANNELS-1:0]           tx_rdy_in,
    input  logic [32*NUM_CHANNELS-1:0]        rx_data_in,
    input  logic [NUM_CHANNELS-1:0]           rx_vld_in,
    output logic [NUM_CHANNELS-1:0]           locked_out,
    output logic [CNT_WIDTH*NUM_CHANNELS-1:0] err_cnt_out,
    output logic [CNT_WIDTH*NUM_CHANNELS-1:0] frm_cnt_out
);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        hssl_lpbk_chan #(
            .FRAME_WORDS (FRAME_WORDS),
            .MISS_LIMIT  (MISS_LIMIT),
            .CNT_WIDTH   (CNT_WIDTH),
            .SYNC_WORD   (SYNC_WORD),
            .SEED        (SEED_BASE | 32'(c))
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .enable_in   (enable_in),
            .clear_in    (clear_in),
            .tx_data_out (tx_data_out[32*c +: 32]),
            .tx_vld_out  (tx_vld_out[c]),
            .tx_rdy_in   (tx_rdy_in[c]),
            .rx_data_in  (rx_data_in[32*c +: 32]),
            .rx_vld_in   (rx_vld_in[c]),
            .locked_out  (locked_out[c]),
            .err_cnt_out (err_cnt_out[CNT_WIDTH*c +: CNT_WIDTH]),
            .frm_cnt_out (frm_cnt_out[CNT_WIDTH*c +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_hssl_lpbk_tester.sv
// Scoreboard bench: bench-side loopback with planned corruption, a
// frame-position reference model and a decoupled output monitor.
module tb_hssl_lpbk_tester;

    localparam int NCH = 2;
    localparam int FW  = 16;
    localparam int ML  = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [31:0] SYNC = 32'h5A5A_C3C3;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic                 clk = 1'b0;
    logic                 reset, enable_in, clear_in;
    logic [32*NCH-1:0]    tx_data_out, rx_data_in;
    logic [NCH-1:0]       tx_vld_out, tx_rdy_in, rx_vld_in, locked_out;
    logic [CW*NCH-1:0]    err_cnt_out, frm_cnt_out;

    int checks = 0;
    int errors = 0;

    typedef struct {int ch; logic lk; int err; int frm;} exp_t;
    exp_t exp_q[$];

    int m_locked[NCH], m_pos[NCH], m_miss[NCH], m_bad[NCH], m_err[NCH], m_frm[NCH];
    int tx_n[NCH];
    int cf_lo[NCH], cf_hi[NCH], cp_lo[NCH], cp_hi[NCH];
    bit rand_rdy = 1'b0;

    hssl_lpbk_tester #(
        .NUM_CHANNELS(NCH), .FRAME_WORDS(FW), .MISS_LIMIT(ML), .CNT_WIDTH(CW), .SYNC_WORD(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .enable_in(enable_in), .clear_in(clear_in),
        .tx_data_out(tx_data_out), .tx_vld_out(tx_vld_out), .tx_rdy_in(tx_rdy_in),
        .rx_data_in(rx_data_in), .rx_vld_in(rx_vld_in), .locked_out(locked_out),
        .err_cnt_out(err_cnt_out), .frm_cnt_out(frm_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected word at a frame position: sync, then seed advanced pos-1 times
    function automatic logic [31:0] ref_word(input int c, input int pos);
        logic [31:0] s;
        s = 32'hACE1_0000 | 32'(c);
        if (pos == 0) return SYNC;
        for (int k = 1; k < pos; k++) s = {s[30:0], ^(s & TAPS)};
        return s;
    endfunction

    function automatic bit hit(input int c, input int n);
        return (n / FW >= cf_lo[c]) && (n / FW <= cf_hi[c]) &&
               (n % FW >= cp_lo[c]) && (n % FW <= cp_hi[c]);
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_word(input int c, input logic [31:0] w);
        if (m_locked[c] == 0) begin
            if (w == SYNC) begin
                m_locked[c] = 1; m_pos[c] = 1; m_miss[c] = 0; m_bad[c] = 0;
            end
        end else if (m_pos[c] == 0) begin
            if (w == SYNC) begin
                m_pos[c] = 1; m_bad[c] = 0;
            end else begin
                m_err[c] = sat(m_err[c] + 1); m_locked[c] = 0;
            end
        end else begin
            if (w != ref_word(c, m_pos[c])) begin
                m_err[c] = sat(m_err[c] + 1); m_miss[c]++; m_bad[c] = 1;
            end else begin
                m_miss[c] = 0;
            end
            if (m_miss[c] >= ML) m_locked[c] = 0;
            else if (m_pos[c] == FW - 1) begin
                if (m_bad[c] == 0) m_frm[c] = sat(m_frm[c] + 1);
                m_pos[c] = 0;
            end else m_pos[c]++;
        end
    endtask

    task automatic no_plan();
        for (int c = 0; c < NCH; c++) begin
            cf_lo[c] = -1; cf_hi[c] = -2; cp_lo[c] = 0; cp_hi[c] = 0;
        end
    endtask

    // Link: observe TX transfers, loop them (possibly corrupted) into RX, push expectations
    initial begin : link
        logic [31:0] d, w;
        logic [NCH-1:0] prev_stall;
        logic [31:0] prev_data[NCH];
        rx_vld_in = '0;
        rx_data_in = '0;
        prev_stall = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_vld_in = '0;
                prev_stall = '0;
                for (int c = 0; c < NCH; c++) begin
                    m_locked[c] = 0; m_pos[c] = 0; m_miss[c] = 0; m_bad[c] = 0;
                    m_err[c] = 0; m_frm[c] = 0; tx_n[c] = 0;
                end
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    d = tx_data_out[32*c +: 32];
                    if (prev_stall[c])
                        check($sformatf("stall_hold_ch%0d", c), {tx_vld_out[c], d}, {1'b1, prev_data[c]});
                    prev_stall[c] = tx_vld_out[c] & ~tx_rdy_in[c];
                    prev_data[c] = d;
                    if (tx_vld_out[c] && tx_rdy_in[c]) begin
                        check($sformatf("tx_word_ch%0d_n%0d", c, tx_n[c]), d, ref_word(c, tx_n[c] % FW));
                        w = hit(c, tx_n[c]) ? (d ^ (32'h1 << $urandom_range(0, 31))) : d;
                        model_word(c, w);
                        rx_vld_in[c] = 1'b1;
                        rx_data_in[32*c +: 32] = w;
                        tx_n[c]++;
                    end else begin
                        rx_vld_in[c] = 1'b0;
                    end
                    if (rx_vld_in[c] || clear_in) begin
                        if (clear_in) begin
                            m_err[c] = 0; m_frm[c] = 0;
                        end
                        exp_q.push_back('{ch: c, lk: m_locked[c][0], err: m_err[c], frm: m_frm[c]});
                    end
                end
            end
        end
    end

    // Monitor: every expectation pushed before an edge is compared just after it
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("locked_ch%0d", e.ch), locked_out[e.ch], e.lk);
                check($sformatf("err_cnt_ch%0d", e.ch), err_cnt_out[CW*e.ch +: CW], e.err);
                check($sformatf("frm_cnt_ch%0d", e.ch), frm_cnt_out[CW*e.ch +: CW], e.frm);
            end
        end
    end

    initial begin : rdy_drv
        tx_rdy_in = '1;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++)
                tx_rdy_in[c] = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic wait_tx(input int c, input int n);
        int t = 0;
        while (tx_n[c] < n && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (tx_n[c] < n) begin
            errors++;
            $display("FAIL wait_tx_ch%0d timeout actual=%0d required=%0d", c, tx_n[c], n);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (tx_vld_out != '0 && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        check("tx_idle", tx_vld_out, '0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        @(posedge clk); #1;
        clear_in = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input int c, input int lk, input int err, input int frm);
        check($sformatf("%s_locked_ch%0d", tag, c), locked_out[c], lk[0]);
        check($sformatf("%s_err_ch%0d", tag, c), err_cnt_out[CW*c +: CW], err);
        check($sformatf("%s_frm_ch%0d", tag, c), frm_cnt_out[CW*c +: CW], frm);
    endtask

    initial begin : stim
        int base, t;
        no_plan();
        reset = 1'b0; enable_in = 1'b0; clear_in = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_tx_vld", tx_vld_out, '0);
        check("rst_tx_data", tx_data_out, '0);
        for (int c = 0; c < NCH; c++) chk_cnt("rst", c, 0, 0, 0);
        @(posedge clk); #3 reset = 1'b0;
        @(posedge clk); #1;

        // Plain loopback, 10 frames
        enable_in = 1'b1;
        @(negedge clk);
        check("vld_before_edge", tx_vld_out, '0);
        @(posedge clk); #1;
        check("vld_first", tx_vld_out, 2'b11);
        check("first_sync_ch0", tx_data_out[31:0], SYNC);
        @(posedge clk); #1;
        check("word1_ch0", tx_data_out[31:0], 32'hACE1_0000);
        check("word1_ch1", tx_data_out[63:32], 32'hACE1_0001);
        wait_tx(0, 9*FW + 1);
        enable_in = 1'b0;
        wait_idle();
        for (int c = 0; c < NCH; c++) chk_cnt("lpbk", c, 1, 0, 10);

        // Single bit error in payload word 5 of frame 3 on ch0
        pulse_clear();
        base = tx_n[0] / FW;
        cf_lo[0] = base + 3; cf_hi[0] = base + 3; cp_lo[0] = 5; cp_hi[0] = 5;
        enable_in = 1'b1;
        wait_tx(0, (base + 9)*FW + 1);
        enable_in = 1'b0;
        wait_idle();
        no_plan();
        chk_cnt("single", 0, 1, 1, 9);
        chk_cnt("single", 1, 1, 0, 10);

        // Lock loss: payload words 3..6 of the second frame on ch1
        pulse_clear();
        base = tx_n[1] / FW;
        cf_lo[1] = base + 1; cf_hi[1] = base + 1; cp_lo[1] = 3; cp_hi[1] = 6;
        enable_in = 1'b1;
        wait_tx(1, (base + 1)*FW + 7);
        check("lock_drop_ch1", locked_out[1], 1'b0);
        wait_tx(1, (base + 2)*FW + 1);
        enable_in = 1'b0;
        wait_idle();
        no_plan();
        chk_cnt("lockloss", 1, 1, 4, 2);
        chk_cnt("lockloss", 0, 1, 0, 3);

        // Random backpressure, stop mid-frame
        pulse_clear();
        rand_rdy = 1'b1;
        base = tx_n[0];
        enable_in = 1'b1;
        wait_tx(0, base + 2*FW + 7);
        enable_in = 1'b0;
        wait_idle();
        rand_rdy = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("stop_frame_whole_ch%0d", c), tx_n[c] % FW, 0);
            check($sformatf("bp_err_ch%0d", c), err_cnt_out[CW*c +: CW], 0);
        end

        // Saturation (21 errors into a 4-bit counter), then clear on an error cycle
        @(posedge clk); #1;
        pulse_clear();
        base = tx_n[0] / FW;
        cf_lo[0] = base; cf_hi[0] = base + 6; cp_lo[0] = 2; cp_hi[0] = 4;
        enable_in = 1'b1;
        wait_tx(0, (base + 6)*FW);
        check("sat_err_ch0", err_cnt_out[CW-1:0], CMAX);
        t = 0;
        while (!(tx_vld_out[0] && hit(0, tx_n[0])) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        clear_in = 1'b1;
        @(posedge clk); #1;
        clear_in = 1'b0;
        check("clear_wins_ch0", err_cnt_out[CW-1:0], 0);
        enable_in = 1'b0;
        wait_idle();
        no_plan();

        // Reset at word 7 of a frame
        enable_in = 1'b1;
        wait_tx(0, tx_n[0] + 7);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx_vld", tx_vld_out, '0);
        check("mid_rst_tx_data", tx_data_out, '0);
        for (int c = 0; c < NCH; c++) chk_cnt("mid_rst", c, 0, 0, 0);
        @(posedge clk);
        @(posedge clk); #3 reset = 1'b0;
        t = 0;
        while (tx_vld_out[0] !== 1'b1 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("post_rst_sync_ch0", {tx_vld_out[0], tx_data_out[31:0]}, {1'b1, SYNC});
        check("post_rst_sync_ch1", {tx_vld_out[1], tx_data_out[63:32]}, {1'b1, SYNC});
        wait_tx(0, FW + 1);
        enable_in = 1'b0;
        wait_idle();
        for (int c = 0; c < NCH; c++) chk_cnt("post_rst", c, 1, 0, 2);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
